// File: rtl/seq_div_pkg.sv
// rtl/seq_div_pkg.sv - FSM states, counter sizing and sign helpers for seq_div
package seq_div_pkg;

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    // Widest DATAWIDTH the sign helpers below support
    localparam int MAX_W = 64;

    function automatic int cnt_width(input int w);
        return $clog2(w + 1);
    endfunction

    function automatic logic [MAX_W-1:0] cond_neg(input logic [MAX_W-1:0] x, input logic en);
        return en ? (~x + MAX_W'(1)) : x;
    endfunction

    function automatic logic [MAX_W-1:0] abs_val(input logic [MAX_W-1:0] x, input logic sign);
        return cond_neg(x, sign);
    endfunction

endpackage

// File: rtl/seq_div_if.sv
// rtl/seq_div_if.sv - operand/result handshake bundle for seq_div (div_zero with SEQ_DIV_DIVZ_EN)
interface seq_div_if #(parameter int DATAWIDTH = 32);

    logic                 in_valid;
    logic                 in_ready;
    logic [DATAWIDTH-1:0] a;
    logic [DATAWIDTH-1:0] b;
    logic                 out_valid;
    logic                 out_ready;
    logic [DATAWIDTH-1:0] quot;
    logic [DATAWIDTH-1:0] rem;
`ifdef SEQ_DIV_DIVZ_EN
    logic                 div_zero;

    modport master (output in_valid, a, b, out_ready,
                    input  in_ready, out_valid, quot, rem, div_zero);
    modport slave  (input  in_valid, a, b, out_ready,
                    output in_ready, out_valid, quot, rem, div_zero);
`else
    modport master (output in_valid, a, b, out_ready,
                    input  in_ready, out_valid, quot, rem);
    modport slave  (input  in_valid, a, b, out_ready,
                    output in_ready, out_valid, quot, rem);
`endif

endinterface

// File: rtl/seq_div_step.sv
// rtl/seq_div_step.sv - one combinational restoring-division step
module seq_div_step #(
    parameter int W = 32
) (
    input  logic [W:0]   i_prem,
    input  logic         i_bit,
    input  logic [W-1:0] i_dvs,
    output logic [W:0]   o_prem,
    output logic         o_qbit
);

    logic [W+1:0] w_shift;
    logic [W+1:0] w_diff;

    // One extra bit beyond the remainder so the trial subtraction's sign is visible
    assign w_shift = {i_prem, i_bit};
    assign w_diff  = w_shift - {2'b00, i_dvs};
    assign o_qbit  = ~w_diff[W+1];
    assign o_prem  = o_qbit ? w_diff[W:0] : w_shift[W:0];

endmodule

// File: rtl/seq_div.sv
// rtl/seq_div.sv - multi-cycle signed divider, truncating quotient/remainder, one step per cycle
// SEQ_DIV_DIVZ_EN: adds div_zero and a short-circuit path for b==0.
module seq_div
    import seq_div_pkg::*;
#(
    parameter int DATAWIDTH = 32
) (
    input  logic     clk,
    input  logic     rst,
    seq_div_if.slave io
);

    localparam int W  = DATAWIDTH;
    localparam int CW = cnt_width(DATAWIDTH);

    state_t         r_state;
    state_t         w_next;
    logic [W:0]     r_prem;
    logic [W-1:0]   r_dvd;
    logic [W-1:0]   r_dvs;
    logic [W-1:0]   r_quot;
    logic [W-1:0]   r_rem;
    logic           r_neg_q;
    logic           r_neg_r;
    logic [CW-1:0]  r_cnt;
    logic [W:0]     w_step_prem;
    logic           w_qbit;
    logic           w_b_zero;

`ifdef SEQ_DIV_DIVZ_EN
    logic r_div_zero;

    assign w_b_zero    = (io.b == '0);
    assign io.div_zero = r_div_zero;
`else
    assign w_b_zero = 1'b0;
`endif

    // r_dvd shifts dividend bits out of the top and quotient bits in at the bottom
    seq_div_step #(.W(W)) u_step (
        .i_prem (r_prem),
        .i_bit  (r_dvd[W-1]),
        .i_dvs  (r_dvs),
        .o_prem (w_step_prem),
        .o_qbit (w_qbit)
    );

    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next       = r_state;
        io.in_ready  = 1'b0;
        io.out_valid = 1'b0;
        case (r_state)
            IDLE: begin
                io.in_ready = ~rst;
                if (io.in_valid) w_next = w_b_zero ? DONE : CALC;
            end
            CALC: if (r_cnt == CW'(1)) w_next = FIX;
            FIX:  w_next = DONE;
            DONE: begin
                io.out_valid = 1'b1;
                if (io.out_ready) w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_prem  <= '0;
            r_dvd   <= '0;
            r_dvs   <= '0;
            r_neg_q <= 1'b0;
            r_neg_r <= 1'b0;
            r_cnt   <= '0;
            r_quot  <= '0;
            r_rem   <= '0;
        end else begin
            case (r_state)
                IDLE: if (io.in_valid) begin
                    r_prem  <= '0;
                    r_dvd   <= W'(abs_val(MAX_W'(io.a), io.a[W-1]));
                    r_dvs   <= W'(abs_val(MAX_W'(io.b), io.b[W-1]));
                    r_neg_q <= io.a[W-1] ^ io.b[W-1];
                    r_neg_r <= io.a[W-1];
                    r_cnt   <= CW'(W);
                    if (w_b_zero) begin
                        r_quot <= '1;
                        r_rem  <= io.a;
                    end
                end
                CALC: begin
                    r_prem <= w_step_prem;
                    r_dvd  <= {r_dvd[W-2:0], w_qbit};
                    r_cnt  <= r_cnt - CW'(1);
                end
                FIX: begin
                    r_quot <= W'(cond_neg(MAX_W'(r_dvd), r_neg_q));
                    r_rem  <= W'(cond_neg(MAX_W'(r_prem[W-1:0]), r_neg_r));
                end
                default: ;
            endcase
        end
    end

`ifdef SEQ_DIV_DIVZ_EN
    always_ff @(posedge clk) begin
        if (rst)
            r_div_zero <= 1'b0;
        else if (r_state == IDLE && io.in_valid)
            r_div_zero <= w_b_zero;
        else if (r_state == DONE && io.out_ready)
            r_div_zero <= 1'b0;
    end
`endif

    assign io.quot = r_quot;
    assign io.rem  = r_rem;

endmodule

// File: tb/tb_seq_div.sv
// tb/tb_seq_div.sv - self-checking bench for seq_div: vector table, corner sequences, random scoreboard
module tb_seq_div;

    localparam int W = 32;
    // out_valid rises at edge k+W+1 (visible to the consumer at edge k+W+2)
    localparam int LAT_EDGES = W + 1;
    localparam int N_RAND = 1000;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] q;
        logic [W-1:0] r;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_tests = 0;
    int   n_fail = 0;

    seq_div_if #(.DATAWIDTH(W)) dif ();

    seq_div #(.DATAWIDTH(W)) u_dut (
        .clk (clk),
        .rst (rst),
        .io  (dif)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [2*W-1:0] ref_div(input logic [W-1:0] a, input logic [W-1:0] b);
        longint sa;
        longint sb;
        longint q;
        longint r;
        sa = longint'(signed'(a));
        sb = longint'(signed'(b));
        q  = sa / sb;
        r  = sa % sb;
        return {q[W-1:0], r[W-1:0]};
    endfunction

    task automatic run_op(input logic [W-1:0] ia, input logic [W-1:0] ib, input int exp_lat,
                          input int hold, output logic [W-1:0] oq, output logic [W-1:0] orr);
        int n;
        logic [W-1:0] sq;
        logic [W-1:0] sr;
        n = 0;
        while (!dif.in_ready && n < 100) begin
            tick;
            n++;
        end
        check("in_ready before accept", W'(dif.in_ready), W'(1));
        dif.a = ia;
        dif.b = ib;
        dif.in_valid = 1'b1;
        dif.out_ready = 1'b0;
        tick;
        dif.in_valid = 1'b0;
        dif.a = $urandom;
        dif.b = $urandom;
        n = 0;
        while (!dif.out_valid && n < 200) begin
            tick;
            n++;
        end
        check("latency", W'(n), W'(exp_lat));
        sq = dif.quot;
        sr = dif.rem;
        for (int i = 0; i < hold; i++) begin
            tick;
            check("backpressure hold", W'(dif.quot == sq && dif.rem == sr && dif.out_valid && !dif.in_ready), W'(1));
        end
        oq = dif.quot;
        orr = dif.rem;
        dif.out_ready = 1'b1;
        tick;
        dif.out_ready = 1'b0;
        check("out_valid after handshake", W'(dif.out_valid), W'(0));
        check("in_ready after handshake", W'(dif.in_ready), W'(1));
    endtask

    initial begin
        vec_t vt[13];
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic [2*W-1:0] exp_q[$];
        logic [2*W-1:0] e;
        int seen;
        int issued;
        int received;
        int cyc;

        vt[0]  = '{32'd7,        32'd3,        32'd2,        32'd1};
        vt[1]  = '{-32'sd7,      32'd3,        -32'sd2,      -32'sd1};
        vt[2]  = '{32'd7,        -32'sd3,      -32'sd2,      32'd1};
        vt[3]  = '{-32'sd7,      -32'sd3,      32'd2,        -32'sd1};
        vt[4]  = '{32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'd0};
        vt[5]  = '{32'h80000000, 32'h80000000, 32'd1,        32'd0};
        vt[6]  = '{32'd100,      32'd7,        32'd14,       32'd2};
        vt[7]  = '{32'd0,        32'd5,        32'd0,        32'd0};
        vt[8]  = '{32'hFFFFFFFF, 32'h80000000, 32'd0,        32'hFFFFFFFF};
        vt[9]  = '{32'h7FFFFFFF, 32'd1,        32'h7FFFFFFF, 32'd0};
        vt[10] = '{32'd5,        32'd7,        32'd0,        32'd5};
        vt[11] = '{32'h80000000, 32'd3,        32'hD5555556, 32'hFFFFFFFE};
        vt[12] = '{32'h7FFFFFFF, 32'h80000000, 32'd0,        32'h7FFFFFFF};

        dif.in_valid = 1'b0;
        dif.out_ready = 1'b0;
        dif.a = '0;
        dif.b = '0;

        tick;
        tick;
        check("reset in_ready", W'(dif.in_ready), W'(0));
        check("reset out_valid", W'(dif.out_valid), W'(0));
        check("reset quot", dif.quot, W'(0));
        check("reset rem", dif.rem, W'(0));
`ifdef SEQ_DIV_DIVZ_EN
        check("reset div_zero", W'(dif.div_zero), W'(0));
`endif
        rst = 1'b0;
        tick;
        check("in_ready after reset", W'(dif.in_ready), W'(1));

        for (int i = 0; i < 13; i++) begin
            run_op(vt[i].a, vt[i].b, LAT_EDGES, 0, q, r);
            check($sformatf("vec%0d quot", i), q, vt[i].q);
            check($sformatf("vec%0d rem", i), r, vt[i].r);
        end

        run_op(32'd1000, -32'sd33, LAT_EDGES, 10, q, r);
        check("backpressure quot", q, -32'sd30);
        check("backpressure rem", r, 32'd10);

        // Abort: reset mid-computation must drop the operation
        dif.a = 32'd100;
        dif.b = 32'd7;
        dif.in_valid = 1'b1;
        tick;
        dif.in_valid = 1'b0;
        repeat (5) tick;
        rst = 1'b1;
        tick;
        check("in_ready during reset", W'(dif.in_ready), W'(0));
        check("quot cleared by reset", dif.quot, W'(0));
        check("rem cleared by reset", dif.rem, W'(0));
        rst = 1'b0;
        seen = 0;
        repeat (40) begin
            tick;
            if (dif.out_valid) seen = 1;
        end
        check("aborted op produced no result", W'(seen), W'(0));
        run_op(32'd100, 32'd7, LAT_EDGES, 0, q, r);
        check("after abort quot", q, 32'd14);
        check("after abort rem", r, 32'd2);

`ifdef SEQ_DIV_DIVZ_EN
        dif.a = -32'sd5;
        dif.b = 32'd0;
        dif.in_valid = 1'b1;
        tick;
        dif.in_valid = 1'b0;
        check("divz out_valid next cycle", W'(dif.out_valid), W'(1));
        check("divz quot", dif.quot, 32'hFFFFFFFF);
        check("divz rem", dif.rem, -32'sd5);
        check("divz flag", W'(dif.div_zero), W'(1));
        dif.out_ready = 1'b1;
        tick;
        dif.out_ready = 1'b0;
        check("divz flag clears", W'(dif.div_zero), W'(0));
        run_op(32'd9, 32'd4, LAT_EDGES, 0, q, r);
        check("after divz flag", W'(dif.div_zero), W'(0));
        check("after divz quot", q, 32'd2);
        check("after divz rem", r, 32'd1);
`endif

        // Random regression with random in_valid/out_ready against the arithmetic model
        issued = 0;
        received = 0;
        cyc = 0;
        while (received < N_RAND && cyc < 80000) begin
            if (issued < N_RAND && $urandom_range(0, 3) != 0) begin
                dif.in_valid = 1'b1;
                dif.a = ($urandom_range(0, 15) == 0) ? 32'h80000000 : $urandom;
                dif.b = $urandom >> $urandom_range(0, 31);
                if (dif.b == '0) dif.b = 32'd1;
                if ($urandom_range(0, 1) == 1) dif.b = -dif.b;
            end else begin
                dif.in_valid = 1'b0;
                dif.a = $urandom;
                dif.b = $urandom;
            end
            dif.out_ready = 1'($urandom_range(0, 1));
            if (dif.in_valid && dif.in_ready) begin
                exp_q.push_back(ref_div(dif.a, dif.b));
                issued++;
            end
            if (dif.out_valid && dif.out_ready) begin
                if (exp_q.size() == 0) begin
                    check("random unexpected result", W'(1), W'(0));
                end else begin
                    e = exp_q.pop_front();
                    check("random quot", dif.quot, e[2*W-1:W]);
                    check("random rem", dif.rem, e[W-1:0]);
                end
                received++;
            end
            tick;
            cyc++;
        end
        dif.in_valid = 1'b0;
        dif.out_ready = 1'b0;
        check("random results received", W'(received), W'(N_RAND));
        check("random scoreboard drained", W'(exp_q.size()), W'(0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
